// File: rtl/mdio_ctrl_pkg.sv
// Shared MDIO frame field positions, opcodes and arbiter FSM encoding.
package mdio_ctrl_pkg;

    localparam logic [1:0]  OP_WRITE       = 2'b01;
    localparam logic [1:0]  OP_READ        = 2'b10;
    localparam int unsigned OP_MSB         = 29;
    localparam int unsigned OP_LSB         = 28;
    localparam int unsigned DATA_MSB       = 15;
    localparam int unsigned FRAME_BITS_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mdio_rr_arb.sv
// Round-robin pointer and next-grant select for the MDIO request arbiter.
module mdio_rr_arb #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    input  logic [IW-1:0]    adv_idx,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_idx
);

    logic [IW-1:0] r_ptr;
    int unsigned   w_j;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_j         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = (32'(r_ptr) + k) % N_REQ;
            if (!grant_valid && req[w_j]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(w_j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= (adv_idx == IW'(N_REQ - 1)) ? '0 : adv_idx + IW'(1);
        end
    end

endmodule

// File: rtl/mdio_req_arbiter.sv
// Round-robin sharing of one MDIO transaction generator between N_REQ requesters.
// Optional watchdog abort is built when MDIO_TIMEOUT_EN is defined.
module mdio_req_arbiter
    import mdio_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_frame,
    output logic [N_REQ-1:0]     done,
    output logic [DATA_MSB:0]    rsp_data,
    output logic                 busy,
    output logic                 err,
    output logic                 gen_start,
    output logic [31:0]          gen_t_data,
    input  logic                 gen_mdc,
    input  logic                 gen_data_rdy,
    input  logic [15:0]          gen_rd_data
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(FRAME_BITS + 1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mdio_req_arbiter: unsupported parameter set");
    end

    state_t            r_state;
    logic [IW-1:0]     r_grant;
    logic              r_is_read;
    logic [CW-1:0]     r_edges;
    logic              r_mdc_prev;
    logic [N_REQ-1:0]  r_done;
    logic [DATA_MSB:0] r_rsp;
    logic              r_busy;
    logic              r_start;
    logic [31:0]       r_tdata;

    logic              w_gnt_valid;
    logic [IW-1:0]     w_gnt_idx;
    logic [31:0]       w_sel_frame;
    logic              w_mdc_rise;
    logic              w_adv;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_complete;

    mdio_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .clk        (clk),
        .rst_n      (reset),
        .req        (req),
        .adv        (w_adv),
        .adv_idx    (r_grant),
        .grant_valid(w_gnt_valid),
        .grant_idx  (w_gnt_idx)
    );

    assign w_sel_frame = req_frame[32*w_gnt_idx +: 32];
    assign w_mdc_rise  = gen_mdc & ~r_mdc_prev;
    assign w_adv       = (r_state == ST_DONE);
    assign w_onehot    = N_REQ'(1) << r_grant;
    // Reads finish only on the generator strobe; everything else counts mdc edges.
    assign w_complete  = r_is_read ? gen_data_rdy
                                   : (w_mdc_rise && r_edges == CW'(FRAME_BITS - 1));

`ifdef MDIO_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_is_read  <= 1'b0;
            r_edges    <= '0;
            r_mdc_prev <= 1'b0;
            r_done     <= '0;
            r_rsp      <= '0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_tdata    <= '0;
`ifdef MDIO_TIMEOUT_EN
            r_tmo      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_mdc_prev <= gen_mdc;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_tdata   <= w_sel_frame;
                        r_grant   <= w_gnt_idx;
                        r_is_read <= (w_sel_frame[OP_MSB:OP_LSB] == OP_READ);
                        r_busy    <= 1'b1;
                        r_start   <= 1'b1;
                        r_state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_start <= 1'b0;
                    r_edges <= '0;
`ifdef MDIO_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_complete) begin
                        r_rsp   <= r_is_read ? gen_rd_data : '0;
                        r_done  <= w_onehot;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
`ifdef MDIO_TIMEOUT_EN
                    else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp   <= '1;
                        r_err   <= 1'b1;
                        r_done  <= w_onehot;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
`endif
                    else begin
                        if (!r_is_read && w_mdc_rise) begin
                            r_edges <= r_edges + CW'(1);
                        end
`ifdef MDIO_TIMEOUT_EN
                        r_tmo <= r_tmo + TW'(1);
`endif
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_rsp   <= '0;
`ifdef MDIO_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign rsp_data   = r_rsp;
    assign busy       = r_busy;
    assign gen_start  = r_start;
    assign gen_t_data = r_tdata;

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// Directed self-checking bench for mdio_req_arbiter (N_REQ=3, 32-edge frames).
module tb_mdio_req_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] req_frame;
    logic [2:0]  done;
    logic [15:0] rsp_data;
    logic        busy;
    logic        err;
    logic        gen_start;
    logic [31:0] gen_t_data;
    logic        gen_mdc;
    logic        gen_data_rdy;
    logic [15:0] gen_rd_data;

    int total = 0;
    int bad   = 0;

    mdio_req_arbiter #(
        .N_REQ         (3),
        .FRAME_BITS    (32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_frame   (req_frame),
        .done        (done),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err         (err),
        .gen_start   (gen_start),
        .gen_t_data  (gen_t_data),
        .gen_mdc     (gen_mdc),
        .gen_data_rdy(gen_data_rdy),
        .gen_rd_data (gen_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (gen_start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        logic flag;
        logic [2:0] exp_done;

        reset        = 1'b0;
        req          = '0;
        req_frame    = '0;
        gen_mdc      = 1'b0;
        gen_data_rdy = 1'b0;
        gen_rd_data  = '0;
        step();
        step();
        check("reset_outputs", {10'd0, done, rsp_data, busy, err, gen_start, gen_t_data}, 64'd0);
        reset = 1'b1;
        step();

        // Single read on requester 0, with a stray strobe during LAUNCH.
        req_frame[31:0] = 32'h6AB8_7654;
        req             = 3'b001;
        wait_start(10, n);
        check("rd_start_latency", 64'(n), 64'd1);
        check("rd_t_data", 64'(gen_t_data), 64'h6AB8_7654);
        check("rd_busy", 64'(busy), 64'd1);
        gen_data_rdy = 1'b1;
        gen_rd_data  = 16'hBAD0;
        step();
        gen_data_rdy = 1'b0;
        check("rd_start_one_cycle", 64'(gen_start), 64'd0);
        step();
        step();
        check("rd_launch_rdy_ignored", 64'(done), 64'd0);
        gen_data_rdy = 1'b1;
        gen_rd_data  = 16'h1234;
        step();
        gen_data_rdy = 1'b0;
        check("rd_done", 64'(done), 64'b001);
        check("rd_data", 64'(rsp_data), 64'h1234);
        check("rd_busy_drop", 64'(busy), 64'd0);
        check("rd_err", 64'(err), 64'd0);
        req = 3'b000;
        step();
        check("rd_done_pulse", 64'(done), 64'd0);
        gen_data_rdy = 1'b1;
        step();
        gen_data_rdy = 1'b0;
        step();
        check("idle_rdy_ignored", {done, 1'b0, busy, gen_start}, 64'd0);

        // Single write on requester 1: 32 mdc edges, stray strobe mid-frame.
        req_frame[63:32] = 32'h5AB8_BEEF;
        req              = 3'b010;
        wait_start(10, n);
        check("wr_start_latency", 64'(n), 64'd1);
        check("wr_t_data", 64'(gen_t_data), 64'h5AB8_BEEF);
        step();
        flag = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            gen_mdc = 1'b1;
            if (i == 10) begin
                gen_data_rdy = 1'b1;
                gen_rd_data  = 16'hFACE;
            end
            step();
            gen_data_rdy = 1'b0;
            if (i < 32) begin
                if (done !== 3'b000) flag = 1'b1;
            end else begin
                check("wr_done", 64'(done), 64'b010);
                check("wr_rsp_zero", 64'(rsp_data), 64'd0);
                check("wr_busy_drop", 64'(busy), 64'd0);
                req = 3'b000;
            end
            gen_mdc = 1'b0;
            step();
        end
        check("wr_no_early_done", 64'(flag), 64'd0);
        check("wr_done_pulse", 64'(done), 64'd0);

        // Requester 2 drops req and rewrites its frame mid-flight.
        req_frame[95:64] = 32'h6123_4567;
        req              = 3'b100;
        wait_start(10, n);
        check("drop_start_latency", 64'(n), 64'd1);
        step();
        req              = 3'b000;
        req_frame[95:64] = 32'hDEAD_BEEF;
        step();
        step();
        check("drop_t_data_held", 64'(gen_t_data), 64'h6123_4567);
        check("drop_busy", 64'(busy), 64'd1);
        gen_data_rdy = 1'b1;
        gen_rd_data  = 16'h0F0F;
        step();
        gen_data_rdy = 1'b0;
        check("drop_done", 64'(done), 64'b100);
        step();
        check("drop_t_data_idle", 64'(gen_t_data), 64'h6123_4567);

        // Contention: all three requesting, expect 0,1,2,0,1,2.
        req_frame = {32'h6000_0002, 32'h6000_0001, 32'h6000_0000};
        req       = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_start(10, n);
            check("rr_start_gap", 64'(n), (t == 0) ? 64'd1 : 64'd2);
            check("rr_t_data", 64'(gen_t_data), 64'h6000_0000 + 64'(t % 3));
            step();
            gen_data_rdy = 1'b1;
            gen_rd_data  = 16'hA000 + 16'(t);
            step();
            gen_data_rdy = 1'b0;
            exp_done = 3'b001 << (t % 3);
            check("rr_done", 64'(done), 64'(exp_done));
            check("rr_rsp", 64'(rsp_data), 64'hA000 + 64'(t));
        end
        req = 3'b000;
        step();

        // Long read with no strobe, then reset mid-transaction.
        req_frame[31:0] = 32'h6000_00AA;
        req             = 3'b001;
        wait_start(10, n);
        check("hang_start_latency", 64'(n), 64'd1);
        step();
        flag = 1'b0;
`ifdef MDIO_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            step();
            if (done !== 3'b000) flag = 1'b1;
        end
        check("tmo_no_early_done", 64'(flag), 64'd0);
        step();
        check("tmo_done", 64'(done), 64'b001);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_rsp", 64'(rsp_data), 64'hFFFF);
        wait_start(10, n);
        check("tmo_regrant", 64'(n), 64'd2);
        step();
`else
        for (int i = 0; i < 80; i++) begin
            step();
            if (busy !== 1'b1 || err !== 1'b0 || done !== 3'b000) flag = 1'b1;
        end
        check("no_tmo_busy_held", 64'(flag), 64'd0);
`endif
        reset = 1'b0;
        #1;
        check("midreset_outputs", {10'd0, done, rsp_data, busy, err, gen_start, gen_t_data}, 64'd0);
        step();
        step();
        reset = 1'b1;
        wait_start(2, n);
        check("post_reset_start", 64'(gen_start === 1'b1 && n >= 1 && n <= 2), 64'd1);
        check("post_reset_t_data", 64'(gen_t_data), 64'h6000_00AA);
        step();
        gen_data_rdy = 1'b1;
        gen_rd_data  = 16'h5555;
        step();
        gen_data_rdy = 1'b0;
        check("post_reset_done", 64'(done), 64'b001);
        check("post_reset_rsp", 64'(rsp_data), 64'h5555);
        req = 3'b000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
